// File: rtl/wb_stage.sv
// wb_stage: write-back stage owning CP0 Status/Cause/EPC/Count/Compare; commits exceptions/ERET and drives flush.
// Optional macro CP0_TIMER_INT_EN enables the Count/Compare timer interrupt (TI on IP7).
module wb_stage #(
   parameter logic [31:0] EXC_ENTRY = 32'hBFC00380,
   parameter int MS_TO_WS_BUS_WD = 120
) (
   input  logic                       clk,
   input  logic                       resetn,
   input  logic                       ms_to_ws_valid,
   output logic                       ws_allowin,
   input  logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
   input  logic [5:0]                 ext_int_in,
   output logic                       rf_we,
   output logic [4:0]                 rf_waddr,
   output logic [31:0]                rf_wdata,
   output logic [37:0]                ws_to_ds_fw_bus,
   output logic                       ws_flush,
   output logic [31:0]                ws_flush_pc,
   output logic                       cp0_status_exl,
   output logic                       cp0_status_ie,
   output logic                       ws_int_pending,
   output logic [31:0]                debug_wb_pc,
   output logic [3:0]                 debug_wb_rf_wen,
   output logic [4:0]                 debug_wb_rf_wnum,
   output logic [31:0]                debug_wb_rf_wdata
);
   logic ws_valid_q, ws_valid_d, ws_ready_go;
   logic [MS_TO_WS_BUS_WD-1:0] bus_q;
   logic [7:0] im_q, im_d;
   logic exl_q, exl_d, ie_q, ie_d, bd_q, bd_d;
   logic [4:0] excode_q, excode_d;
   logic [5:0] ip_hw_q;
   logic [1:0] ip_sw_q, ip_sw_d;
   logic [31:0] epc_q, epc_d;
   logic [31:0] count, compare, status_r, cause_r, cp0_rdata;
   logic ti;
   logic [31:0] pc, result, rt_value;
   logic [4:0] dest, excode;
   logic [7:0] cp0_addr;
   logic gr_we, excp, eret, mtc0, mfc0, bd_in;
   logic do_excp, do_eret, do_mtc0, normal;
   logic wr_status, wr_cause, wr_epc;

   assign pc       = bus_q[31:0];
   assign result   = bus_q[63:32];
   assign dest     = bus_q[68:64];
   assign gr_we    = bus_q[69];
   assign excode   = bus_q[74:70];
   assign excp     = bus_q[75];
   assign mfc0     = bus_q[76];
   assign mtc0     = bus_q[77];
   assign eret     = bus_q[78];
   assign cp0_addr = bus_q[86:79];
   assign rt_value = bus_q[118:87];
   assign bd_in    = bus_q[119];

   assign ws_ready_go = 1'b1;
   assign ws_allowin  = !ws_valid_q | ws_ready_go;

   assign do_excp = ws_valid_q & excp;
   assign do_eret = ws_valid_q & eret & !excp;
   assign do_mtc0 = ws_valid_q & mtc0 & !excp & !eret;
   assign normal  = ws_valid_q & !excp & !eret & !mtc0;

   assign wr_status = do_mtc0 & (cp0_addr == 8'h60);
   assign wr_cause  = do_mtc0 & (cp0_addr == 8'h68);
   assign wr_epc    = do_mtc0 & (cp0_addr == 8'h70);

   // IP7 is shared between external line 5 and the timer interrupt
   assign status_r = {9'b0, 1'b1, 6'b0, im_q, 6'b0, exl_q, ie_q};
   assign cause_r  = {bd_q, ti, 14'b0, ip_hw_q[5] | ti, ip_hw_q[4:0], ip_sw_q, 1'b0, excode_q, 2'b0};
   assign cp0_rdata = cp0_addr == 8'h48 ? count :
                      cp0_addr == 8'h58 ? compare :
                      cp0_addr == 8'h60 ? status_r :
                      cp0_addr == 8'h68 ? cause_r :
                      cp0_addr == 8'h70 ? epc_q : 32'b0;

   assign ws_flush          = ws_valid_q & (excp | eret);
   assign ws_flush_pc       = !ws_flush ? 32'b0 : do_eret ? epc_q : EXC_ENTRY;
   assign rf_we             = normal & (mfc0 | gr_we);
   assign rf_waddr          = ws_valid_q ? dest : 5'b0;
   assign rf_wdata          = !ws_valid_q ? 32'b0 : mfc0 ? cp0_rdata : result;
   assign ws_to_ds_fw_bus   = {rf_we, rf_waddr, rf_wdata};
   assign cp0_status_exl    = exl_q;
   assign cp0_status_ie     = ie_q;
   assign ws_int_pending    = ie_q & !exl_q & |(im_q & cause_r[15:8]);
   assign debug_wb_pc       = ws_valid_q ? pc : 32'b0;
   assign debug_wb_rf_wen   = {4{rf_we}};
   assign debug_wb_rf_wnum  = rf_waddr;
   assign debug_wb_rf_wdata = rf_wdata;

   always_comb begin
      ws_valid_d = ws_flush ? 1'b0 : ws_allowin ? ms_to_ws_valid : ws_valid_q;
      exl_d      = do_excp ? 1'b1 : do_eret ? 1'b0 : wr_status ? rt_value[1] : exl_q;
      ie_d       = wr_status ? rt_value[0] : ie_q;
      im_d       = wr_status ? rt_value[15:8] : im_q;
      ip_sw_d    = wr_cause ? rt_value[9:8] : ip_sw_q;
      bd_d       = do_excp ? bd_in : bd_q;
      excode_d   = do_excp ? excode : excode_q;
      epc_d      = (do_excp & !exl_q) ? (bd_in ? pc - 32'd4 : pc) : wr_epc ? rt_value : epc_q;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         ws_valid_q <= 1'b0;
         bus_q      <= '0;
         im_q       <= '0;
         exl_q      <= 1'b0;
         ie_q       <= 1'b0;
         bd_q       <= 1'b0;
         excode_q   <= '0;
         ip_hw_q    <= '0;
         ip_sw_q    <= '0;
         epc_q      <= '0;
      end else begin
         ws_valid_q <= ws_valid_d;
         if (ms_to_ws_valid && ws_allowin) bus_q <= ms_to_ws_bus;
         im_q       <= im_d;
         exl_q      <= exl_d;
         ie_q       <= ie_d;
         bd_q       <= bd_d;
         excode_q   <= excode_d;
         ip_hw_q    <= ext_int_in;
         ip_sw_q    <= ip_sw_d;
         epc_q      <= epc_d;
      end
   end

`ifdef CP0_TIMER_INT_EN
   logic tick_q, ti_q;
   logic [31:0] count_q, compare_q;
   logic wr_count, wr_compare;
   assign wr_count   = do_mtc0 & (cp0_addr == 8'h48);
   assign wr_compare = do_mtc0 & (cp0_addr == 8'h58);
   // Count advances every other cycle; a Compare write acknowledges the timer interrupt
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         tick_q    <= 1'b0;
         ti_q      <= 1'b0;
         count_q   <= '0;
         compare_q <= '0;
      end else begin
         tick_q    <= ~tick_q;
         count_q   <= wr_count ? rt_value : count_q + {31'b0, tick_q};
         compare_q <= wr_compare ? rt_value : compare_q;
         ti_q      <= wr_compare ? 1'b0 : (count_q == compare_q) ? 1'b1 : ti_q;
      end
   end
   assign count   = count_q;
   assign compare = compare_q;
   assign ti      = ti_q;
`else
   assign count   = 32'b0;
   assign compare = 32'b0;
   assign ti      = 1'b0;
`endif
endmodule
